prog_mem: RTL and testbench
===========================

# prog_mem

Parametrised, writable successor to the fixed program ROM: instruction memory of 2^ADDR_W words of DATA_W bits, with a registered fetch port for the core and a byte-stream loader that writes a new program without resynthesis. The loader assembles big-endian bytes into words and commits them at auto-incrementing addresses. It sits between the boot/debug link (byte source) and the core's fetch stage; the core must stall while `busy` is high.

## Interface
- ADDR_W, 4: address width; DEPTH = 2^ADDR_W words.
- DATA_W, 16: instruction width; must be a multiple of 8. BYTES = DATA_W/8.

- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- fetch_req  in  1  read request.
- fetch_addr  in  ADDR_W  read address.
- instruction  out  DATA_W  registered read data.
- fetch_valid  out  1  instruction updated this cycle.
- ld_start  in  1  begin load, single-cycle pulse.
- ld_base  in  ADDR_W  first write address, sampled on ld_start.
- ld_len  in  ADDR_W+1  word count 1..DEPTH, sampled on ld_start.
- ld_byte  in  8  load data byte.
- ld_valid  in  1  ld_byte valid.
- ld_ready  out  1  loader accepts a byte.
- busy  out  1  load in progress; fetch is blocked.
- done  out  1  one-cycle pulse: load finished.
- err  out  1  last ld_start was rejected.

## Operation
- Reset values: instruction=0 (nop), fetch_valid=0, ld_ready=0, busy=0, done=0, err=0; FSM → IDLE. Memory contents are not touched by reset.
- FSM states:
  - IDLE: serves fetches.
    - On ld_start with 1 ≤ ld_len ≤ DEPTH: latch wr_addr=ld_base and words_left=ld_len, clear err and the byte counter, go to LOAD.
    - Otherwise ld_start sets err=1 and the FSM stays in IDLE.
  - LOAD: ld_ready=1, busy=1. Each cycle with ld_valid&ld_ready shifts ld_byte into the word assembly register, first byte = MSB. When byte BYTES is accepted, go to WRITE.
  - WRITE: ld_ready=0, busy=1. Write mem[wr_addr]=assembled word; wr_addr+1 mod DEPTH (wraps DEPTH-1→0); words_left-1. Go to DONE if words_left becomes 0, otherwise go back to LOAD.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Fetch:
  - In IDLE/DONE, fetch_req registers instruction=mem[fetch_addr] and sets fetch_valid=1 on the next cycle.
  - With no request, instruction holds its value and fetch_valid=0.
  - In LOAD/WRITE, fetch_req is ignored: fetch_valid=0 and instruction holds.
- ld_start outside IDLE is ignored; err is unchanged.
- ld_valid while ld_ready=0: the byte is dropped, with no error.
- ld_len width ADDR_W+1 lets DEPTH be expressed; ld_len=DEPTH with any base writes every word exactly once.

## Timing
- Fetch latency 1 cycle: request at edge N, data and fetch_valid visible after edge N+1. Back-to-back requests give one word per cycle.
- Load throughput: BYTES accept cycles plus 1 WRITE cycle per word. Minimum load of L words = L·(BYTES+1) cycles after ld_start, then done 1 cycle later.
- ld_start and fetch_req in the same IDLE cycle: the fetch is served (valid next cycle) and the load starts; busy rises the next cycle.
- A word written in WRITE at edge N is readable by a fetch requested in DONE (edge N+1) or later.
- rst_n low mid-load: next edge returns to IDLE. The partial word is discarded, already-committed words remain, and done does not pulse.

## Configuration
- PROG_MEM_INIT_EN defined: memory is initialised at configuration time to the boot program and all other words are 0. The boot program is:
  - word0 = 16'hB401 (subi r2 1)
  - word1 = 16'hF400 (out r2)
  - word2 = 16'h8100 (jmp 1)
- PROG_MEM_INIT_EN undefined: memory is uninitialised (X in simulation); the core must not fetch before a load completes. All other behaviour is identical.

## Test plan
- Reset, then fetch addr 0,1,2 back-to-back (PROG_MEM_INIT_EN set) -> instruction = 16'hB401, 16'hF400, 16'h8100 on consecutive cycles, fetch_valid high for 3 cycles, starting 1 cycle after the first request.
- ld_start base=3 len=2, bytes 12 34 56 78 with ld_valid always high -> mem[3]=16'h1234, mem[4]=16'h5678; done pulses exactly 7 cycles after ld_start; readback matches.
- Wrap: base=DEPTH-1, len=2, bytes AA BB CC DD -> mem[15]=16'hAABB, mem[0]=16'hCCDD, no other word changed.
- ld_len=0, then ld_len=DEPTH+1 -> err=1, FSM stays IDLE, busy=0. A following valid ld_start clears err.
- fetch_req held high during a load -> fetch_valid=0 and instruction frozen while busy. ld_start pulsed mid-load is ignored. ld_valid gaps stretch the load with no data loss.
- rst_n low after 1 byte of a word -> IDLE next cycle, target word unchanged, done never pulses. A new load then succeeds.

Source files
------------

// File: rtl/prog_mem.sv
// Writable program memory: 1-cycle registered fetch port plus a byte-stream loader (big-endian words, auto-incrementing address).
// Define PROG_MEM_INIT_EN to preload the boot program; otherwise contents start uninitialised.
module prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [DATA_W-1:0] o_instruction,
  output logic              o_fetch_valid,
  input  logic              i_ld_start,
  input  logic [ADDR_W-1:0] i_ld_base,
  input  logic [ADDR_W:0]   i_ld_len,
  input  logic [7:0]        i_ld_byte,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int BYTES = DATA_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W:0]   r_words_left;
  logic [BCW-1:0]    r_byte_cnt;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_instruction;
  logic              r_fetch_valid;
  logic              r_err;
  logic              w_len_ok;
  logic              w_last_byte;
  logic              w_fetch_en;

`ifdef PROG_MEM_INIT_EN
  logic [DATA_W-1:0] r_mem [DEPTH] = '{0: DATA_W'(16'hB401), 1: DATA_W'(16'hF400),
                                       2: DATA_W'(16'h8100), default: '0};
`else
  logic [DATA_W-1:0] r_mem [DEPTH];
`endif

  assign w_len_ok    = (i_ld_len != '0) && (i_ld_len <= (ADDR_W+1)'(DEPTH));
  assign w_last_byte = (r_byte_cnt == BCW'(BYTES-1));
  assign w_fetch_en  = i_fetch_req && ((r_state == S_IDLE) || (r_state == S_DONE));

  assign o_instruction = r_instruction;
  assign o_fetch_valid = r_fetch_valid;
  assign o_err         = r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    o_ld_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (r_state)
      S_IDLE: if (i_ld_start && w_len_ok) w_next = S_LOAD;
      S_LOAD: begin
        o_ld_ready = 1'b1;
        o_busy     = 1'b1;
        if (i_ld_valid && w_last_byte) w_next = S_WRITE;
      end
      S_WRITE: begin
        o_busy = 1'b1;
        w_next = (r_words_left == (ADDR_W+1)'(1)) ? S_DONE : S_LOAD;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Loader datapath; a rejected start only touches err.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_err        <= 1'b0;
      r_wr_addr    <= '0;
      r_words_left <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_ld_start) begin
            if (w_len_ok) begin
              r_wr_addr    <= i_ld_base;
              r_words_left <= i_ld_len;
              r_byte_cnt   <= '0;
              r_err        <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (i_ld_valid) begin
            r_word     <= (r_word << 8) | DATA_W'(i_ld_byte);
            r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BCW'(1);
          end
        end
        S_WRITE: begin
          r_wr_addr    <= r_wr_addr + ADDR_W'(1);
          r_words_left <= r_words_left - (ADDR_W+1)'(1);
        end
        default: ;
      endcase
    end
  end

  // Storage is never reset; a reset edge landing on WRITE must not commit the word.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && (r_state == S_WRITE)) r_mem[r_wr_addr] <= r_word;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_instruction <= '0;
      r_fetch_valid <= 1'b0;
    end else begin
      r_fetch_valid <= w_fetch_en;
      if (w_fetch_en) r_instruction <= r_mem[i_fetch_addr];
    end
  end
endmodule

// File: tb/tb_prog_mem.sv
// Scoreboard bench for prog_mem: random loads checked against an array model, fetches checked by a decoupled monitor.
`timescale 1ns/1ps
module tb_prog_mem;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int BYTES  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_fetch_req;
  logic [ADDR_W-1:0] i_fetch_addr;
  logic [DATA_W-1:0] o_instruction;
  logic              o_fetch_valid;
  logic              i_ld_start;
  logic [ADDR_W-1:0] i_ld_base;
  logic [ADDR_W:0]   i_ld_len;
  logic [7:0]        i_ld_byte;
  logic              i_ld_valid;
  logic              o_ld_ready;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  always #5 clk = ~clk;

  prog_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_fetch_req(i_fetch_req), .i_fetch_addr(i_fetch_addr),
    .o_instruction(o_instruction), .o_fetch_valid(o_fetch_valid),
    .i_ld_start(i_ld_start), .i_ld_base(i_ld_base), .i_ld_len(i_ld_len),
    .i_ld_byte(i_ld_byte), .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] model_mem [DEPTH];
  bit                known [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int                due_q [$];
  logic [7:0]        bytes_q [$];
  logic [DATA_W-1:0] mon_exp;
  int                mon_due;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_fetch(input int a);
    i_fetch_req  = 1'b1;
    i_fetch_addr = a[ADDR_W-1:0];
    exp_q.push_back(model_mem[a]);
    due_q.push_back(cyc + 1);
  endtask

  // Monitor: every fetch_valid must match the oldest expected fetch, in the cycle it is due.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_fetch_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL fetch_unexpected: got valid instr %0h, expected no fetch (cycle %0d)", o_instruction, cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          mon_due = due_q.pop_front();
          check("fetch_data", o_instruction, mon_exp);
          check("fetch_cycle", cyc, mon_due);
        end
      end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL fetch_missing: got no fetch_valid, expected %0h due at cycle %0d", exp_q[0], due_q[0]);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
    end
  end

  task automatic readback();
    for (int a = 0; a < DEPTH; a++) begin
      if (known[a]) begin
        issue_fetch(a);
        tick();
      end
    end
    i_fetch_req = 1'b0;
    tick();
    tick();
    check("fetch_drain", exp_q.size(), 0);
  endtask

  // Runs one load of bytes_q (topped up with random bytes) and updates the model on done.
  task automatic do_load(input int base, input int len, input bit gaps, input bit hold_fetch,
                         input int fa, input bit poke_start);
    int nb, idx, cycles;
    bit got_done;
    logic [DATA_W-1:0] frozen, w;
    nb = len * BYTES;
    while (bytes_q.size() < nb) bytes_q.push_back(8'($urandom));
    i_ld_base  = base[ADDR_W-1:0];
    i_ld_len   = len[ADDR_W:0];
    i_ld_start = 1'b1;
    if (fa >= 0) issue_fetch(fa);
    tick();
    i_ld_start  = 1'b0;
    i_fetch_req = 1'b0;
    cycles = 1;
    check("busy_rise", o_busy, 1);
    check("err_clear", o_err, 0);
    frozen = o_instruction;
    if (hold_fetch) begin
      i_fetch_req  = 1'b1;
      i_fetch_addr = ADDR_W'($urandom);
    end
    idx = 0;
    got_done = 1'b0;
    while (!got_done && cycles < 400) begin
      if (o_done) begin
        got_done = 1'b1;
      end else begin
        if (o_busy) check("instr_frozen", o_instruction, frozen);
        i_ld_start = poke_start && (cycles == 3);
        if (i_ld_start) i_ld_len = '0;
        i_ld_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        i_ld_byte  = (idx < nb) ? bytes_q[idx] : 8'($urandom);
        if (i_ld_valid && o_ld_ready) idx++;
        tick();
        cycles++;
      end
    end
    i_ld_valid = 1'b0;
    i_ld_start = 1'b0;
    if (!got_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", cycles);
      i_fetch_req = 1'b0;
    end else begin
      check("bytes_used", idx, nb);
      if (!gaps) check("done_latency", cycles, len * (BYTES + 1) + 1);
      for (int wi = 0; wi < len; wi++) begin
        w = '0;
        for (int b = 0; b < BYTES; b++) w = (w << 8) | DATA_W'(bytes_q[wi * BYTES + b]);
        model_mem[(base + wi) % DEPTH] = w;
        known[(base + wi) % DEPTH] = 1'b1;
      end
      check("err_after_load", o_err, 0);
      if (hold_fetch) issue_fetch(base);
      tick();
      i_fetch_req = 1'b0;
      check("done_one_cycle", o_done, 0);
      check("busy_after_done", o_busy, 0);
    end
    bytes_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    i_fetch_req = 1'b0; i_fetch_addr = '0;
    i_ld_start = 1'b0; i_ld_base = '0; i_ld_len = '0;
    i_ld_byte = '0; i_ld_valid = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      model_mem[a] = '0;
      known[a] = 1'b0;
    end
`ifdef PROG_MEM_INIT_EN
    model_mem[0] = 16'hB401;
    model_mem[1] = 16'hF400;
    model_mem[2] = 16'h8100;
    for (int a = 0; a < DEPTH; a++) known[a] = 1'b1;
`endif
    repeat (3) tick();
    check("rst_instruction", o_instruction, 0);
    check("rst_fetch_valid", o_fetch_valid, 0);
    check("rst_ld_ready", o_ld_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    rst_n = 1'b1;
    tick();

`ifdef PROG_MEM_INIT_EN
    for (int a = 0; a < 3; a++) begin
      issue_fetch(a);
      tick();
    end
    i_fetch_req = 1'b0;
    tick();
    tick();
`endif

    // Full-depth load from a random base: every word written once.
    do_load($urandom_range(0, DEPTH - 1), DEPTH, 1'b0, 1'b0, -1, 1'b0);
    readback();

    bytes_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_load(3, 2, 1'b0, 1'b0, -1, 1'b0);
    check("model_w3", model_mem[3], 16'h1234);
    readback();

    bytes_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_load(DEPTH - 1, 2, 1'b0, 1'b0, -1, 1'b0);
    readback();

    // Rejected starts.
    i_ld_len = '0; i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    check("err_len0", o_err, 1);
    check("busy_len0", o_busy, 0);
    check("ready_len0", o_ld_ready, 0);
    tick();
    check("err_holds", o_err, 1);
    i_ld_len = 5'(DEPTH + 1); i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    check("err_len_big", o_err, 1);
    check("busy_len_big", o_busy, 0);

    // Valid start clears err; fetch in the same cycle is served; gaps, held fetch, mid-load start.
    do_load(7, 3, 1'b1, 1'b1, 2, 1'b1);
    readback();

    // Reset after one byte of a word.
    i_ld_base = 3; i_ld_len = 1; i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    i_ld_valid = 1'b1; i_ld_byte = 8'hEE;
    tick();
    i_ld_byte = 8'h77; rst_n = 1'b0;
    tick();
    check("midrst_busy", o_busy, 0);
    check("midrst_ready", o_ld_ready, 0);
    check("midrst_done", o_done, 0);
    check("midrst_instr", o_instruction, 0);
    rst_n = 1'b1; i_ld_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("midrst_no_done", o_done, 0);
    end
    readback();
    do_load(3, 1, 1'b0, 1'b0, -1, 1'b0);
    readback();

    for (int t = 0; t < 6; t++) begin
      do_load($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), -1, 1'b0);
      readback();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
